// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu shared definitions.
// funct3 encodings, FSM states and default widths.
package riscv_lsu_pkg;

   localparam int LSU_MEM_AW = 13;
   localparam int LSU_XLEN   = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FAULT,
      S_LD_RD,
      S_LD_RESP,
      S_ST_WR,
      S_RMW_RD,
      S_RMW_WR
   } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_lane.sv
// riscv_lsu lane alignment.
// Load lane extract/extend and sub-word store merge.
module lsu_lane_align
   import riscv_lsu_pkg::*;
#(
   parameter int XLEN = LSU_XLEN
) (
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      off_i,
   input  logic [XLEN-1:0] rdata_i,
   input  logic [15:0]     wdata_i,
   output logic [XLEN-1:0] ld_data_o,
   output logic [XLEN-1:0] st_data_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // pick the addressed byte and halfword lanes
   always_comb begin
      byte_s = rdata_i[{off_i, 3'b000} +: 8];
      half_s = rdata_i[{off_i[1], 4'b0000} +: 16];
   end

   // extend the selected lane for the load response
   always_comb begin
      unique case (funct3_i)
         F3_B:    ld_data_o = {{(XLEN-8){byte_s[7]}}, byte_s};
         F3_BU:   ld_data_o = {{(XLEN-8){1'b0}}, byte_s};
         F3_H:    ld_data_o = {{(XLEN-16){half_s[15]}}, half_s};
         F3_HU:   ld_data_o = {{(XLEN-16){1'b0}}, half_s};
         default: ld_data_o = rdata_i;
      endcase
   end

   // replace only the target lane of the old word
   always_comb begin
      st_data_o = rdata_i;
      if (funct3_i == F3_B)
         st_data_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      else if (funct3_i == F3_H)
         st_data_o[{off_i[1], 4'b0000} +: 16] = wdata_i;
   end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: RV32I load/store unit.
// Word memory initiator with RMW for SB/SH.
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int MEM_AW = LSU_MEM_AW,
   parameter int XLEN   = LSU_XLEN
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_fault,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic              mem_re,
   output logic              mem_we,
   input  logic [XLEN-1:0]   mem_rdata
);

   lsu_state_e          state_q;
   logic                store_q;
   logic [2:0]          f3_q;
   logic [MEM_AW+1:0]   addr_q;
   logic [XLEN-1:0]     wdata_q;

   logic                mis, oor, ill, acc_fault;
   logic [XLEN-1:0]     ld_data, st_data;

   // request checks evaluated at accept time
   always_comb begin
      mis = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
            (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
      oor = |req_addr[XLEN-1:MEM_AW+2];
      unique case (req_funct3)
         F3_B, F3_H, F3_W: ill = 1'b0;
         F3_BU, F3_HU:     ill = req_store;
         default:          ill = 1'b1;
      endcase
      acc_fault = mis | oor | ill;
   end

   // FSM and latched request
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         store_q <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  store_q <= req_store;
                  f3_q    <= req_funct3;
                  addr_q  <= req_addr[MEM_AW+1:0];
                  wdata_q <= req_wdata;
                  if (acc_fault)
                     state_q <= S_FAULT;
                  else if (!req_store)
                     state_q <= S_LD_RD;
                  else if (req_funct3 == F3_W)
                     state_q <= S_ST_WR;
                  else
                     state_q <= S_RMW_RD;
               end
            end
            S_LD_RD:  state_q <= S_LD_RESP;
            S_RMW_RD: state_q <= S_RMW_WR;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   lsu_lane_align #(.XLEN(XLEN)) u_align (
      .funct3_i  (f3_q),
      .off_i     (addr_q[1:0]),
      .rdata_i   (mem_rdata),
      .wdata_i   (wdata_q[15:0]),
      .ld_data_o (ld_data),
      .st_data_o (st_data)
   );

   // outputs decoded from state and latched request only
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_fault = 1'b0;
      resp_rdata = '0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      unique case (state_q)
         S_IDLE: req_ready = 1'b1;
         S_FAULT: begin
            resp_valid = 1'b1;
            resp_fault = 1'b1;
         end
         S_LD_RD: begin
            mem_addr = addr_q[MEM_AW+1:2];
            mem_re   = 1'b1;
         end
         S_LD_RESP: begin
            mem_addr   = addr_q[MEM_AW+1:2];
            resp_valid = 1'b1;
            resp_rdata = store_q ? '0 : ld_data;
         end
         S_ST_WR: begin
            mem_addr   = addr_q[MEM_AW+1:2];
            mem_we     = 1'b1;
            mem_wdata  = wdata_q;
            resp_valid = 1'b1;
         end
         S_RMW_RD: begin
            mem_addr = addr_q[MEM_AW+1:2];
            mem_re   = 1'b1;
         end
         S_RMW_WR: begin
            mem_addr   = addr_q[MEM_AW+1:2];
            mem_we     = 1'b1;
            mem_wdata  = st_data;
            resp_valid = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// riscv_lsu testbench.
// Directed plan items plus random mix against a word-array model.
module tb_riscv_lsu;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [12:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_re;
   logic        mem_we;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:8191];
   logic [31:0] ref_mem [0:8191];
   logic        bd_we = 1'b0;
   logic [12:0] bd_addr = '0;
   logic [31:0] bd_data = '0;

   always #5 clk = ~clk;

   riscv_lsu dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_fault (resp_fault),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata)
   );

   // data memory: one-cycle read, plus a backdoor for preloading
   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic poke(input int w, input logic [31:0] d);
      @(negedge clk);
      bd_we = 1'b1;
      bd_addr = w[12:0];
      bd_data = d;
      ref_mem[w] = d;
      @(posedge clk);
      #1 bd_we = 1'b0;
   endtask

   // reference: result of one request from the architectural rules
   function automatic void model(input bit st, input logic [2:0] f3,
      input logic [31:0] a, input logic [31:0] wd,
      output logic [31:0] erd, output bit ef, output int elat,
      output int ere, output int ewe, output logic [31:0] ewd);
      logic [31:0] w, b, h;
      int sh, hs;
      bit mis, oor, legal;
      mis = ((f3 == 1 || f3 == 5) && a % 2 != 0) ||
            (f3 == 2 && a % 4 != 0);
      oor = (a >> 15) != 0;
      legal = st ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
      ef = mis || oor || !legal;
      erd = 0; ere = 0; ewe = 0; ewd = 0;
      if (ef) begin
         elat = 1;
         return;
      end
      w = ref_mem[a / 4];
      sh = (a % 4) * 8;
      hs = ((a % 4) / 2) * 16;
      b = (w >> sh) & 32'hFF;
      h = (w >> hs) & 32'hFFFF;
      if (!st) begin
         elat = 2; ere = 1;
         case (f3)
            0: erd = (b >= 128) ? b - 256 : b;
            4: erd = b;
            1: erd = (h >= 32768) ? h - 65536 : h;
            5: erd = h;
            default: erd = w;
         endcase
      end else begin
         ewe = 1;
         if (f3 == 2) begin
            elat = 1;
            ewd = wd;
         end else begin
            elat = 2; ere = 1;
            if (f3 == 0)
               ewd = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            else
               ewd = (w & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
         end
         ref_mem[a / 4] = ewd;
      end
   endfunction

   task automatic xact(input bit st, input logic [2:0] f3,
      input logic [31:0] a, input logic [31:0] wd, input string tag,
      output logic [31:0] rd, output bit flt, output int lat,
      output int nre, output int nwe,
      output logic [31:0] wa, output logic [31:0] wdv);
      bit done = 0;
      rd = 0; flt = 0; lat = 0; nre = 0; nwe = 0; wa = 0; wdv = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_store = st;
      req_funct3 = f3;
      req_addr = a;
      req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 1; i <= 6 && !done; i++) begin
         if (i > 1) @(negedge clk);
         if (mem_re && mem_we) chk({tag, "_re_we"}, 1, 0);
         nre += int'(mem_re);
         nwe += int'(mem_we);
         if (mem_we) begin
            wa = 32'(mem_addr);
            wdv = mem_wdata;
         end
         if (resp_valid) begin
            lat = i;
            rd = resp_rdata;
            flt = resp_fault;
            done = 1;
         end
      end
      if (!done) chk({tag, "_timeout"}, 0, 1);
   endtask

   task automatic run(input bit st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input string tag);
      logic [31:0] erd, ewd, rd, wa, wdv;
      bit ef, flt;
      int elat, ere, ewe, lat, nre, nwe;
      model(st, f3, a, wd, erd, ef, elat, ere, ewe, ewd);
      xact(st, f3, a, wd, tag, rd, flt, lat, nre, nwe, wa, wdv);
      chk({tag, "_lat"}, lat, elat);
      chk({tag, "_fault"}, 32'(flt), 32'(ef));
      chk({tag, "_rdata"}, rd, erd);
      chk({tag, "_nre"}, nre, ere);
      chk({tag, "_nwe"}, nwe, ewe);
      if (ewe != 0) begin
         chk({tag, "_waddr"}, wa, a / 4);
         chk({tag, "_wdata"}, wdv, ewd);
         @(posedge clk);
         #1 chk({tag, "_mem"}, mem[a / 4], ref_mem[a / 4]);
      end
   endtask

   initial begin
      logic [31:0] erd, ewd, a;
      logic [2:0] f3;
      bit ef, st;
      int elat, ere, ewe, lowcnt, wecnt, recnt;

      // request offered while reset is high must be ignored
      req_valid = 1'b1;
      req_store = 1'b1;
      req_funct3 = 3'b010;
      req_addr = 32'h64;
      req_wdata = 32'hDEADBEEF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 1);
      chk("rst_rvalid", 32'(resp_valid), 0);
      chk("rst_rfault", 32'(resp_fault), 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_re", 32'(mem_re), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_maddr", 32'(mem_addr), 0);
      chk("rst_mwdata", mem_wdata, 0);
      req_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_noacc", 32'(resp_valid | mem_we), 0);

      for (int i = 0; i < 32; i++) poke(i, $urandom);

      run(1, 3'b010, 32'h64, 32'hAAAAAAAA, "sw");
      chk("sw_const", mem[25], 32'hAAAAAAAA);

      poke(25, 32'h8033F0A5);
      run(0, 3'b000, 32'h64, 0, "lb");
      run(0, 3'b100, 32'h67, 0, "lbu");
      run(0, 3'b001, 32'h66, 0, "lh");
      run(0, 3'b101, 32'h64, 0, "lhu");

      poke(25, 32'h11223344);
      run(1, 3'b000, 32'h65, 32'hFFFFFF99, "sb");
      chk("sb_const", mem[25], 32'h11229944);
      run(1, 3'b001, 32'h66, 32'h0000BEEF, "sh");
      chk("sh_const", mem[25], 32'hBEEF9944);

      run(0, 3'b010, 32'h66, 0, "f_lw_mis");
      run(1, 3'b001, 32'h65, 32'h1234, "f_sh_mis");
      run(0, 3'b010, 32'h00008000, 0, "f_oor");
      run(0, 3'b011, 32'h64, 0, "f_f3");

      // request held valid through an RMW: only one accept
      model(1, 3'b000, 32'h71, 32'h5A, erd, ef, elat, ere, ewe, ewd);
      @(negedge clk);
      req_valid = 1'b1;
      req_store = 1'b1;
      req_funct3 = 3'b000;
      req_addr = 32'h71;
      req_wdata = 32'h5A;
      @(posedge clk);
      lowcnt = 0; wecnt = 0; recnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (!req_ready) lowcnt++;
         wecnt += int'(mem_we);
         recnt += int'(mem_re);
      end
      req_valid = 1'b0;
      chk("busy_low", lowcnt, 2);
      chk("busy_we", wecnt, 1);
      chk("busy_re", recnt, 1);
      chk("busy_mem", mem[28], ref_mem[28]);

      // reset during RMW_RD aborts the write
      poke(30, 32'h55667788);
      @(negedge clk);
      req_valid = 1'b1;
      req_store = 1'b1;
      req_funct3 = 3'b000;
      req_addr = 32'h78;
      req_wdata = 32'h12;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("ab_re", 32'(mem_re), 1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("ab_ready", 32'(req_ready), 1);
      chk("ab_we", 32'(mem_we), 0);
      chk("ab_rvalid", 32'(resp_valid), 0);
      reset = 1'b0;
      wecnt = 0;
      repeat (3) begin
         @(negedge clk);
         wecnt += int'(mem_we);
      end
      chk("ab_nowe", wecnt, 0);
      chk("ab_mem", mem[30], 32'h55667788);

      // random mix
      for (int n = 0; n < 150; n++) begin
         st = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0)
            f3 = 3'($urandom_range(0, 7));
         else if (st)
            f3 = 3'($urandom_range(0, 2));
         else
            f3 = 3'($urandom_range(0, 4) == 3 ? 5 : $urandom_range(0, 4));
         a = 32'($urandom_range(0, 127));
         if ($urandom_range(0, 15) == 0)
            a = a | (32'h1 << $urandom_range(15, 31));
         run(st, f3, a, $urandom, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit: initiator side of the word-organised data memory (13-bit word address, 32-bit data, separate read/write enables).
- Accepts RV32I load/store requests from the execute stage and issues word accesses to memory.
- Sub-word stores (SB/SH) use read-modify-write; loads are extracted from the addressed lane and sign/zero-extended.
- Returns a one-cycle response pulse carrying load data or a fault flag.

Parameters:
- MEM_AW, 13, word-address width of the data memory (2^13 words).
- XLEN, 32, data and byte-address width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  LSU can accept a request this cycle
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010)
- req_addr  input  XLEN  byte address from ALU
- req_wdata  input  XLEN  store data, right-aligned
- resp_valid  output  1  single-cycle response pulse
- resp_rdata  output  XLEN  extended load data (0 for stores and faults)
- resp_fault  output  1  misaligned, out-of-range or illegal funct3
- mem_addr  output  MEM_AW  word address = addr[MEM_AW+1:2]
- mem_wdata  output  XLEN  word write data
- mem_re  output  1  memory read enable
- mem_we  output  1  memory write enable
- mem_rdata  input  XLEN  memory read data, valid the cycle after mem_re

Behaviour:
- Output decode
  - All mem_* and resp_* outputs are decoded from state and latched request registers only.
  - There is no combinational path from req_* to mem_*.
- FSM states: IDLE, FAULT, LD_RD, LD_RESP, ST_WR, RMW_RD, RMW_WR.
- IDLE
  - req_ready = 1. On req_valid: latch store, funct3, addr, wdata.
  - Fault check at accept:
    - halfword with addr[0] = 1, or word with addr[1:0] != 0;
    - addr[XLEN-1:MEM_AW+2] != 0;
    - funct3 not in the legal set (loads: 000/001/010/100/101; stores: 000/001/010).
  - On fault → FAULT. Otherwise: load → LD_RD, SW → ST_WR, SB/SH → RMW_RD.
- FAULT: resp_valid = 1, resp_fault = 1, resp_rdata = 0, no memory access; → IDLE.
- LD_RD: mem_re = 1; → LD_RESP.
- LD_RESP
  - Select lane from mem_rdata: byte lane addr[1:0], halfword lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - resp_valid = 1; → IDLE.
- ST_WR: mem_we = 1, mem_wdata = wdata; resp_valid = 1; → IDLE.
- RMW_RD: mem_re = 1; → RMW_WR.
- RMW_WR
  - mem_wdata = mem_rdata with the target lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH). Other lanes unchanged.
  - mem_we = 1, resp_valid = 1; → IDLE.
- Latency, accept edge to resp_valid high: FAULT 1 cycle, SW 1 cycle, loads 2 cycles, SB/SH 2 cycles.
- req_ready = 0 in every non-IDLE state; req_valid there is ignored. No back-to-back accept: the next accept occurs in IDLE.
- resp has no backpressure; the consumer must take the pulse.
- mem_addr holds the latched word address in all non-IDLE states and 0 in IDLE/FAULT.
- mem_re and mem_we are never both 1.
- Reset
  - Values: state = IDLE; req_ready = 1; resp_valid = 0; resp_fault = 0; resp_rdata = 0; mem_re = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0.
  - Reset mid-RMW aborts the operation: no mem_we is issued and memory keeps the pre-RMW value.
  - A request presented with reset high is not accepted.

Decomposition:
- Shared package riscv_lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - FSM state enum;
  - MEM_AW default.
- One sub-module, lsu_lane_align: purely combinational.
  - Load path: lane select plus sign/zero extension.
  - Store path: lane merge for RMW.
  - Shared by LD_RESP and RMW_WR.

Test Plan:
- SW addr 0x64, wdata 0xAAAAAAAA → mem_we one cycle, mem_addr 25, mem_wdata 0xAAAAAAAA; resp_valid 1 cycle after accept, fault 0.
- Word 25 = 0x8033F0A5:
  - LB addr 0x64 → 0xFFFFFFA5; LBU addr 0x67 → 0x00000080;
  - LH addr 0x66 → 0xFFFF8033; LHU addr 0x64 → 0x0000F0A5;
  - each with resp_valid exactly 2 cycles after accept.
- Word 25 = 0x11223344:
  - SB addr 0x65, wdata 0xFFFFFF99 → mem_re then mem_we with mem_wdata 0x11229944;
  - then SH addr 0x66, wdata 0xBEEF → word reads back 0xBEEF9944.
- Faults, each giving resp_fault 1 cycle after accept with no mem_re/mem_we ever asserted:
  - LW addr 0x66; SH addr 0x65;
  - LW addr 0x00008000 (out of range);
  - load funct3 011.
- Busy and abort:
  - req_valid held during an RMW → only first request accepted; req_ready low for 2 cycles.
  - reset asserted in RMW_RD → next cycle IDLE, no mem_we, word unchanged.
- Power-up reset → all outputs at reset values and req_ready 1. Random load/store mix checked against a reference memory model.
